pi_loop_sequencer: RTL and testbench
====================================

Name: pi_loop_sequencer

Overview:
Drives one PI control iteration per accepted ADC sample by acting as the initiator of pi_pipeline's start/result_valid handshake. It owns the persistent integral register and clamps the result to the DAC range, with anti-windup. It emits the DAC code over a valid/ready handshake. It sits between the ADC reader and the DAC writer and instantiates nothing; pi_pipeline is connected externally.

Parameters:
INPUT_WIDTH, 18, ADC sample / setpoint width (two's complement)
OUTPUT_WIDTH, 32, coefficient, integral and pipeline result width
OUTPUT_RANGE_BITS, 20, DAC code width (signed)
TIMEOUT_CYCLES, 16, WAIT-state cycles before the fault is declared

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  loop enable
integral_clear  in  1  zero the integral register
setpoint  in  INPUT_WIDTH  target value
kp, ki  in  OUTPUT_WIDTH each  gains
adc_valid / adc_ready  in / out  1  sample handshake
adc_data  in  INPUT_WIDTH  measured sample
pipe_start  out  1  pipeline start level
pipe_setpoint, pipe_actual  out  INPUT_WIDTH  held pipeline operands
pipe_kp, pipe_ki, pipe_integral_input  out  OUTPUT_WIDTH  held pipeline operands
pipe_result_valid  in  1  pipeline done
pipe_integral_result, pipe_pi_result  in  OUTPUT_WIDTH  pipeline outputs
pipe_overflow, pipe_underflow  in  1  pipeline range flags
dac_valid / dac_ready  out / in  1  output handshake
dac_data  out  OUTPUT_RANGE_BITS  clamped DAC code
integral  out  OUTPUT_WIDTH  current integral register
clamp_count  out  16  saturating count of clamped iterations
fault  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE. All outputs, operand registers, integral and clamp_count are 0.
- States:
  - IDLE: adc_ready = enable & ~fault. On an adc_valid & adc_ready edge, latch adc_data, setpoint, kp, ki and integral into the pipe_* registers and go to START.
  - START: pipe_start = 1 for exactly this cycle's entry. pipe_result_valid is stale here and ignored. Go to WAIT.
  - WAIT: pipe_start stays 1, operands held stable. On pipe_result_valid go to CAPTURE. If the wait counter reaches TIMEOUT_CYCLES, set fault and go to IDLE.
  - CAPTURE: pipe_start = 0.
    - If pipe_overflow: dac_data = 2^(R-1)-1, integral unchanged, clamp_count++.
    - Else if pipe_underflow: dac_data = -2^(R-1), integral unchanged, clamp_count++.
    - Else: dac_data = pipe_pi_result[R-1:0] and integral <= pipe_integral_result.
    - Go to OUTPUT.
  - OUTPUT: dac_valid = 1, dac_data stable until dac_ready. On the handshake edge go to IDLE.
- pipe_start is low in IDLE, CAPTURE and OUTPUT. This guarantees at least 2 low cycles between runs, so the pipeline sees a fresh rising edge each run.
- Latency with a nominal 5-stage pipeline: dac_valid rises 7 edges after the ADC accept edge (result_valid arrives on WAIT's 5th cycle).
- enable is sampled only in IDLE. A sample already in flight completes, including the DAC handshake. fault is cleared only by enable low for at least 1 cycle.
- integral_clear is honoured in any state and wins over the CAPTURE writeback on the same edge. It does not alter pipe_integral_input during an in-flight run.
- overflow and underflow both high is illegal; overflow takes priority.
- clamp_count saturates at 0xFFFF.
- Asynchronous reset mid-operation returns to IDLE immediately and drops dac_valid and pipe_start.

Decomposition:
- Shared package (pi_pkg): state encoding (IDLE, START, WAIT, CAPTURE, OUTPUT) and a function producing the clamp limits from OUTPUT_RANGE_BITS.
- Optional sub-module pi_output_clamp: combinational select of limit vs truncated result, plus the anti-windup enable. Everything else stays in one FSM module.

Test Plan:
- Nominal path: kp=2, ki=1, setpoint=0, actual=100, integral 0 -> dac_data=300, integral=100, dac_valid 7 edges after accept. A second identical sample -> dac_data=400, integral=200.
- Overflow: kp=2^20, ki=0, actual=1 -> dac_data=0x7FFFF, integral stays 0, clamp_count=1.
- Underflow: kp=2^20, ki=0, actual=0x3FFFF (-1) -> dac_data=0x80000, clamp_count increments.
- Backpressure: hold dac_ready low for 10 cycles -> dac_data/dac_valid stable, adc_ready=0 throughout, and the next sample is accepted only after the handshake.
- Timeout: stub pipeline never asserts result_valid -> fault=1 after 16 WAIT cycles, adc_ready=0. enable low then high -> fault=0 and samples are accepted again.
- Reset/clear: rst_n low during WAIT -> all outputs 0 asynchronously. integral_clear asserted in the CAPTURE cycle -> integral=0.

Source files
------------

// File: rtl/pi_loop_sequencer_pkg.sv
// Shared definitions for the PI loop sequencer.
//   state_t   : sequencer FSM encoding, also exported on the debug port
//   clamp_hi  : largest signed code representable in range_bits bits
//   clamp_lo  : smallest signed code representable in range_bits bits
package pi_loop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  localparam int CLAMP_COUNT_WIDTH = 16;

  function automatic logic signed [63:0] clamp_hi(input int range_bits);
    return (64'sd1 <<< (range_bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] clamp_lo(input int range_bits);
    return -(64'sd1 <<< (range_bits - 1));
  endfunction

endpackage

// File: rtl/pi_loop_sequencer_clamp.sv
// Output limiter with anti-windup decision.
//   overflow, underflow : range flags from the PI pipeline (overflow wins)
//   pi_low              : low OUTPUT_RANGE_BITS of the pipeline PI result
//   dac_code            : limit code or truncated result
//   clamped             : this iteration hit a limit
//   integral_write      : integral may take the pipeline's new value
module pi_loop_sequencer_clamp
  import pi_loop_sequencer_pkg::*;
#(
  parameter int OUTPUT_RANGE_BITS = 20
) (
  input  logic                         overflow,
  input  logic                         underflow,
  input  logic [OUTPUT_RANGE_BITS-1:0] pi_low,
  output logic [OUTPUT_RANGE_BITS-1:0] dac_code,
  output logic                         clamped,
  output logic                         integral_write
);

  localparam logic [OUTPUT_RANGE_BITS-1:0] DAC_HI =
    OUTPUT_RANGE_BITS'(clamp_hi(OUTPUT_RANGE_BITS));
  localparam logic [OUTPUT_RANGE_BITS-1:0] DAC_LO =
    OUTPUT_RANGE_BITS'(clamp_lo(OUTPUT_RANGE_BITS));

  // A clamped iteration freezes the integral so it cannot wind up while
  // the output is pinned at a rail.
  always_comb begin
    dac_code       = pi_low;
    clamped        = 1'b0;
    integral_write = 1'b1;
    if (overflow) begin
      dac_code       = DAC_HI;
      clamped        = 1'b1;
      integral_write = 1'b0;
    end else if (underflow) begin
      dac_code       = DAC_LO;
      clamped        = 1'b1;
      integral_write = 1'b0;
    end
  end

endmodule

// File: rtl/pi_loop_sequencer.sv
// One PI iteration per accepted ADC sample, driving an external pi_pipeline.
//   adc_valid/adc_ready/adc_data : sample input handshake
//   pipe_*  (out)                : start level and held operands to pipeline
//   pipe_*  (in)                 : result_valid, results and range flags
//   dac_valid/dac_ready/dac_data : clamped output handshake
//   integral, clamp_count, fault : loop status
//   state_dbg                    : current FSM state
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the initiator holds valid and data stable until then.
module pi_loop_sequencer
  import pi_loop_sequencer_pkg::*;
#(
  parameter int INPUT_WIDTH       = 18,
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         integral_clear,
  input  logic [INPUT_WIDTH-1:0]       setpoint,
  input  logic [OUTPUT_WIDTH-1:0]      kp,
  input  logic [OUTPUT_WIDTH-1:0]      ki,
  input  logic                         adc_valid,
  output logic                         adc_ready,
  input  logic [INPUT_WIDTH-1:0]       adc_data,
  output logic                         pipe_start,
  output logic [INPUT_WIDTH-1:0]       pipe_setpoint,
  output logic [INPUT_WIDTH-1:0]       pipe_actual,
  output logic [OUTPUT_WIDTH-1:0]      pipe_kp,
  output logic [OUTPUT_WIDTH-1:0]      pipe_ki,
  output logic [OUTPUT_WIDTH-1:0]      pipe_integral_input,
  input  logic                         pipe_result_valid,
  input  logic [OUTPUT_WIDTH-1:0]      pipe_integral_result,
  input  logic [OUTPUT_WIDTH-1:0]      pipe_pi_result,
  input  logic                         pipe_overflow,
  input  logic                         pipe_underflow,
  output logic                         dac_valid,
  input  logic                         dac_ready,
  output logic [OUTPUT_RANGE_BITS-1:0] dac_data,
  output logic [OUTPUT_WIDTH-1:0]      integral,
  output logic [CLAMP_COUNT_WIDTH-1:0] clamp_count,
  output logic                         fault,
  output state_t                       state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                         state, state_nx;
  logic [CW-1:0]                  wait_cnt;
  logic                           accept;
  logic                           timeout;
  logic [OUTPUT_RANGE_BITS-1:0]   clamp_code;
  logic                           clamped;
  logic                           integral_write;
  logic                           unused_pi_hi;

  // Only the DAC-width slice of the PI result is ever used; the rest is
  // represented by the pipeline's range flags.
  assign unused_pi_hi = ^pipe_pi_result[OUTPUT_WIDTH-1:OUTPUT_RANGE_BITS];

  assign adc_ready  = (state == ST_IDLE) && enable && !fault;
  assign accept     = adc_valid && adc_ready;
  // Start is a level held over START and WAIT, so it is low for at least
  // CAPTURE, OUTPUT and IDLE between runs.
  assign pipe_start = (state == ST_START) || (state == ST_WAIT);
  assign dac_valid  = (state == ST_OUTPUT);
  assign timeout    = (state == ST_WAIT) && !pipe_result_valid && (wait_cnt == WAIT_LAST);
  assign state_dbg  = state;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_START;
      // result_valid may still be high from a previous run here; ignore it.
      ST_START:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (pipe_result_valid) state_nx = ST_CAPTURE;
        else if (timeout)      state_nx = ST_IDLE;
      end
      ST_CAPTURE: state_nx = ST_OUTPUT;
      ST_OUTPUT:  if (dac_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  pi_loop_sequencer_clamp #(
    .OUTPUT_RANGE_BITS(OUTPUT_RANGE_BITS)
  ) u_clamp (
    .overflow      (pipe_overflow),
    .underflow     (pipe_underflow),
    .pi_low        (pipe_pi_result[OUTPUT_RANGE_BITS-1:0]),
    .dac_code      (clamp_code),
    .clamped       (clamped),
    .integral_write(integral_write)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      wait_cnt            <= '0;
      pipe_setpoint       <= '0;
      pipe_actual         <= '0;
      pipe_kp             <= '0;
      pipe_ki             <= '0;
      pipe_integral_input <= '0;
      dac_data            <= '0;
      integral            <= '0;
      clamp_count         <= '0;
      fault               <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        pipe_setpoint       <= setpoint;
        pipe_actual         <= adc_data;
        pipe_kp             <= kp;
        pipe_ki             <= ki;
        pipe_integral_input <= integral;
      end

      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;

      // A timeout on the same edge as enable low still latches the fault.
      if (timeout)      fault <= 1'b1;
      else if (!enable) fault <= 1'b0;

      if (state == ST_CAPTURE) begin
        dac_data <= clamp_code;
        if (clamped && (clamp_count != {CLAMP_COUNT_WIDTH{1'b1}}))
          clamp_count <= clamp_count + 1'b1;
      end

      // Clear wins over the writeback from the same CAPTURE cycle.
      if (integral_clear)
        integral <= '0;
      else if ((state == ST_CAPTURE) && integral_write)
        integral <= pipe_integral_result;
    end
  end

endmodule

// File: tb/tb_pi_loop_sequencer.sv
module tb_pi_loop_sequencer;
  import pi_loop_sequencer_pkg::*;

  localparam int IW = 18;
  localparam int OW = 32;
  localparam int RB = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          integral_clear = 1'b0;
  logic [IW-1:0] setpoint = '0;
  logic [OW-1:0] kp = '0;
  logic [OW-1:0] ki = '0;
  logic          adc_valid = 1'b0;
  logic          adc_ready;
  logic [IW-1:0] adc_data = '0;
  logic          pipe_start;
  logic [IW-1:0] pipe_setpoint, pipe_actual;
  logic [OW-1:0] pipe_kp, pipe_ki, pipe_integral_input;
  logic          pipe_result_valid;
  logic [OW-1:0] pipe_integral_result, pipe_pi_result;
  logic          pipe_overflow, pipe_underflow;
  logic          dac_valid;
  logic          dac_ready = 1'b0;
  logic [RB-1:0] dac_data;
  logic [OW-1:0] integral;
  logic [15:0]   clamp_count;
  logic          fault;
  state_t        state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  pi_loop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .integral_clear(integral_clear),
    .setpoint(setpoint), .kp(kp), .ki(ki),
    .adc_valid(adc_valid), .adc_ready(adc_ready), .adc_data(adc_data),
    .pipe_start(pipe_start), .pipe_setpoint(pipe_setpoint), .pipe_actual(pipe_actual),
    .pipe_kp(pipe_kp), .pipe_ki(pipe_ki), .pipe_integral_input(pipe_integral_input),
    .pipe_result_valid(pipe_result_valid), .pipe_integral_result(pipe_integral_result),
    .pipe_pi_result(pipe_pi_result), .pipe_overflow(pipe_overflow),
    .pipe_underflow(pipe_underflow), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .dac_data(dac_data), .integral(integral), .clamp_count(clamp_count),
    .fault(fault), .state_dbg(state_dbg)
  );

  // Pipeline stand-in: result_valid rises stub_lat edges after start rises
  // (counting the first edge that sees start high), results held afterwards.
  int     stub_lat  = 5;
  bit     stub_dead = 1'b0;
  int     stub_cnt;
  longint st_e, st_ni, st_pi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt             <= 0;
      pipe_result_valid    <= 1'b0;
      pipe_integral_result <= '0;
      pipe_pi_result       <= '0;
      pipe_overflow        <= 1'b0;
      pipe_underflow       <= 1'b0;
    end else if (!pipe_start) begin
      stub_cnt          <= 0;
      pipe_result_valid <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt + 1 == stub_lat && !stub_dead) begin
        st_e  = longint'(signed'(pipe_actual)) - longint'(signed'(pipe_setpoint));
        st_ni = longint'(signed'(pipe_integral_input)) + longint'(signed'(pipe_ki)) * st_e;
        st_pi = longint'(signed'(pipe_kp)) * st_e + st_ni;
        pipe_result_valid    <= 1'b1;
        pipe_integral_result <= st_ni[OW-1:0];
        pipe_pi_result       <= st_pi[OW-1:0];
        pipe_overflow        <= (st_pi > 64'sd524287);
        pipe_underflow       <= (st_pi < -64'sd524288);
      end
    end
  end

  // scoreboard
  int            n_vec = 0;
  int            n_err = 0;
  logic [RB-1:0] exp_q[$];
  longint        m_int = 0;
  int            m_clamp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one sample through a full iteration. Starts and ends at a negedge
  // with the sequencer idle.
  task automatic do_sample(input logic [IW-1:0] act, input logic [IW-1:0] sp,
                           input logic [OW-1:0] kp_v, input logic [OW-1:0] ki_v,
                           input int lat, input int bp, input bit clr);
    longint        e, ni, pv;
    bit            clamp;
    logic [RB-1:0] exp_dac;
    int            k;
    stub_lat  = lat;
    adc_data  = act;
    setpoint  = sp;
    kp        = kp_v;
    ki        = ki_v;
    adc_valid = 1'b1;
    dac_ready = 1'b0;
    check_eq("adc_ready_idle", 64'(adc_ready), 64'd1);

    e     = longint'(signed'(act)) - longint'(signed'(sp));
    ni    = m_int + longint'(signed'(ki_v)) * e;
    pv    = longint'(signed'(kp_v)) * e + ni;
    clamp = 1'b1;
    if (pv > 524287)        exp_dac = 20'h7FFFF;
    else if (pv < -524288)  exp_dac = 20'h80000;
    else begin
      exp_dac = pv[RB-1:0];
      clamp   = 1'b0;
    end
    exp_q.push_back(exp_dac);

    @(posedge clk); #1;
    adc_valid = 1'b0;
    adc_data  = IW'($urandom);
    setpoint  = IW'($urandom);
    kp        = $urandom;
    ki        = $urandom;
    @(negedge clk);
    k = 0;
    check_eq("adc_ready_busy", 64'(adc_ready), 64'd0);
    check_eq("pipe_actual", 64'(pipe_actual), 64'(act));
    check_eq("pipe_setpoint", 64'(pipe_setpoint), 64'(sp));
    check_eq("pipe_kp", 64'(pipe_kp), 64'(kp_v));
    check_eq("pipe_integral_input", 64'(pipe_integral_input), 64'(m_int[OW-1:0]));

    while (!dac_valid && k < 40) begin
      integral_clear = clr && (k == lat + 1);
      @(negedge clk);
      k++;
    end
    integral_clear = 1'b0;
    check_eq("dac_latency", 64'(k), 64'(lat + 2));
    check_eq("dac_data", 64'(dac_data), 64'(exp_q.pop_front()));

    if (clamp) m_clamp++;
    else       m_int = ni;
    if (clr)   m_int = 0;

    adc_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_eq("bp_dac_valid", 64'(dac_valid), 64'd1);
      check_eq("bp_dac_data", 64'(dac_data), 64'(exp_dac));
      check_eq("bp_adc_ready", 64'(adc_ready), 64'd0);
    end
    adc_valid = 1'b0;
    dac_ready = 1'b1;
    @(posedge clk); #1;
    dac_ready = 1'b0;
    @(negedge clk);
    check_eq("dac_valid_done", 64'(dac_valid), 64'd0);
    check_eq("integral", 64'(integral), 64'(m_int[OW-1:0]));
    check_eq("clamp_count", 64'(clamp_count), 64'(m_clamp));
    check_eq("adc_ready_after", 64'(adc_ready), 64'd1);
  endtask

  initial begin
    int k;
    int a, s;
    // reset state
    #12;
    check_eq("rst_pipe_start", 64'(pipe_start), 64'd0);
    check_eq("rst_dac_valid", 64'(dac_valid), 64'd0);
    check_eq("rst_adc_ready", 64'(adc_ready), 64'd0);
    check_eq("rst_dac_data", 64'(dac_data), 64'd0);
    check_eq("rst_integral", 64'(integral), 64'd0);
    check_eq("rst_clamp_count", 64'(clamp_count), 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_pipe_kp", 64'(pipe_kp), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // nominal, repeated sample accumulates
    do_sample(18'd100, 18'd0, 32'd2, 32'd1, 5, 0, 1'b0);
    do_sample(18'd100, 18'd0, 32'd2, 32'd1, 5, 0, 1'b0);
    // overflow / underflow rails
    do_sample(18'd1, 18'd0, 32'h0010_0000, 32'd0, 5, 0, 1'b0);
    do_sample(18'h3FFFF, 18'd0, 32'h0010_0000, 32'd0, 5, 0, 1'b0);
    // backpressure
    do_sample(18'd37, 18'd5, 32'd3, 32'd2, 5, 10, 1'b0);
    // clear in CAPTURE wins over writeback
    do_sample(18'd50, 18'd0, 32'd1, 32'd1, 5, 0, 1'b1);

    // timeout
    stub_dead = 1'b1;
    adc_data  = 18'd9;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!fault && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq("timeout_edges", 64'(k), 64'd17);
    check_eq("timeout_fault", 64'(fault), 64'd1);
    check_eq("timeout_adc_ready", 64'(adc_ready), 64'd0);
    check_eq("timeout_pipe_start", 64'(pipe_start), 64'd0);
    check_eq("timeout_dac_valid", 64'(dac_valid), 64'd0);
    check_eq("timeout_integral", 64'(integral), 64'(m_int[OW-1:0]));
    stub_dead = 1'b0;
    enable    = 1'b0;
    @(negedge clk);
    check_eq("fault_cleared", 64'(fault), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    do_sample(18'd20, 18'd10, 32'd4, 32'd1, 5, 0, 1'b0);

    // randomized iterations
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, 262143)) - 131072;
        s = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        a = int'($urandom_range(0, 4000)) - 2000;
        s = int'($urandom_range(0, 4000)) - 2000;
      end
      do_sample(IW'(a), IW'(s), 32'($urandom_range(0, 8)), 32'($urandom_range(0, 3)),
                int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
    end

    // asynchronous reset in WAIT; make sure there is state to wipe
    do_sample(18'd200, 18'd0, 32'd1, 32'd1, 5, 0, 1'b0);
    do_sample(18'd1, 18'd0, 32'h0010_0000, 32'd0, 5, 0, 1'b0);
    adc_data  = 18'd77;
    kp        = 32'd5;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_pipe_start", 64'(pipe_start), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_pipe_start", 64'(pipe_start), 64'd0);
    check_eq("arst_dac_valid", 64'(dac_valid), 64'd0);
    check_eq("arst_integral", 64'(integral), 64'd0);
    check_eq("arst_clamp_count", 64'(clamp_count), 64'd0);
    check_eq("arst_dac_data", 64'(dac_data), 64'd0);
    check_eq("arst_pipe_actual", 64'(pipe_actual), 64'd0);
    check_eq("arst_pipe_kp", 64'(pipe_kp), 64'd0);
    check_eq("arst_pipe_int_in", 64'(pipe_integral_input), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_int   = 0;
    m_clamp = 0;
    exp_q.delete();
    @(negedge clk);
    do_sample(18'd100, 18'd0, 32'd2, 32'd1, 5, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
